ghostbox_cmd_ctrl: RTL and testbench
====================================

Name: ghostbox_cmd_ctrl

Overview:
Command sequencer between the UART receiver and the Ghostbox output resources (seven-segment number register, clicking-noise frequency and enable).
Decodes a byte-oriented opcode/argument protocol from the UART byte stream and replaces the raw i_mode switch routing.
Validates frames, enforces an argument timeout and a link-loss watchdog, and drives registered configuration to the display and clicker.

Parameters:
RX_INVERT, 1, 1 = complement each received byte before decoding (line polarity of the existing link); 0 = use as received
CLK_HZ, 50000000, clock frequency; documentation only, no logic depends on it
ARG_TIMEOUT, 5000000, max cycles to wait for an argument byte after an opcode
LINK_TIMEOUT, 100000000, cycles without a valid command before link-lost; 0 disables the watchdog

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_rx_done  input  1  one-cycle strobe: byte valid on i_rx_byte
i_rx_byte  input  8  received UART byte
o_sevseg_num  output  8  number to seven-segment driver
o_buzz_freq  output  4  clicker frequency code
o_buzz_en  output  1  clicker enable (mute when 0)
o_update  output  1  one-cycle pulse when any output register changes due to a command
o_err  output  1  one-cycle pulse on protocol error
o_err_cnt  output  8  saturating protocol error count
o_link_lost  output  1  high while the watchdog has expired

Behaviour:
- Reset (async, i_rst=1): o_sevseg_num=0, o_buzz_freq=1, o_buzz_en=1, o_update=0, o_err=0, o_err_cnt=0, o_link_lost=0, FSM=IDLE, all counters 0.
- Byte b = RX_INVERT ? ~i_rx_byte : i_rx_byte; sampled only on cycles with i_rx_done=1.
- Opcodes: 0x01 SET_NUM (1 arg), 0x02 SET_FREQ (1 arg), 0x03 MUTE (0 args), 0x04 UNMUTE (0 args). Any other opcode -> error, stay IDLE.
- FSM states: IDLE, WAIT_ARG, APPLY.
- IDLE + rx_done:
  - 0x01/0x02: latch opcode, go to WAIT_ARG, clear arg counter.
  - 0x03/0x04: go to APPLY.
- WAIT_ARG + rx_done: latch arg, go to APPLY.
- WAIT_ARG, arg counter reaches ARG_TIMEOUT-1 without rx_done: error, go to IDLE. If rx_done coincides with timeout, the byte is accepted (rx_done wins).
- APPLY (one cycle), then IDLE:
  - SET_NUM: o_sevseg_num<=arg.
  - SET_FREQ: arg[7:4] must be 0, else error with no change; o_buzz_freq<=arg[3:0]. arg 0x00 is legal (freq 0).
  - MUTE: o_buzz_en<=0. UNMUTE: o_buzz_en<=1.
- Latency: outputs and o_update are visible 2 cycles after the rx_done of the final byte (capture cycle, then APPLY registers).
- o_update pulses only on successful APPLY, even if the value is unchanged.
- Bytes arriving during APPLY are dropped and counted as an error; the UART minimum byte spacing makes this a fault case only.
- Error: o_err pulses 1 cycle; o_err_cnt increments, saturating at 255.
- Watchdog (LINK_TIMEOUT>0):
  - Counter resets on every successful APPLY and counts otherwise.
  - At LINK_TIMEOUT, o_link_lost=1. While high, o_buzz_en is forced to 0 at the port; the internal enable register is preserved.
  - Next successful APPLY clears o_link_lost in the same cycle o_update pulses.
  - Counter saturates; it does not wrap.
- Reset mid-frame: FSM returns to IDLE immediately; a partial frame is discarded and not counted.

Optional Feature:
CMD_CHECKSUM_EN: when defined, every frame carries a trailing checksum byte equal to XOR of all preceding frame bytes (post-inversion). A WAIT_CSUM state follows WAIT_ARG, or follows IDLE for 0-arg opcodes. It is subject to the same ARG_TIMEOUT. Mismatch -> error, no APPLY. Latency: 2 cycles after the checksum byte's rx_done. When undefined, frames are as above and WAIT_CSUM is not built.

Test Plan:
- RX_INVERT=0; send 0x01,0x2A -> o_sevseg_num=0x2A, o_update pulse 2 cycles after second rx_done, o_err_cnt=0.
- RX_INVERT=1; send raw 0xFD,0xF8 (decoded 0x02,0x07) -> o_buzz_freq=7; then raw 0xFD,0xEF (decoded arg 0x10) -> o_err pulse, freq stays 7, o_err_cnt=1.
- ARG_TIMEOUT=16; send 0x01, then no byte for 16 cycles -> o_err pulse, FSM IDLE; then 0x03 -> o_buzz_en=0.
- Send opcode 0x09 300 times -> o_err_cnt saturates at 255; no output change.
- LINK_TIMEOUT=100; idle 100 cycles -> o_link_lost=1, o_buzz_en=0; send 0x04 -> o_link_lost=0, o_buzz_en=1 with o_update.
- Assert i_rst after 0x02 (before arg) -> all outputs return to reset values; following 0x01,0x05 -> o_sevseg_num=5. With CMD_CHECKSUM_EN: 0x01,0x05,0x04 -> applied; 0x01,0x05,0x00 -> o_err, no change.

Source files
------------

// File: rtl/ghostbox_cmd_ctrl.sv
// Ghostbox command sequencer: decodes opcode/argument frames from the UART byte stream into
// display/clicker registers, with argument timeout and link watchdog. Macro: CMD_CHECKSUM_EN.
module ghostbox_cmd_ctrl #(
  parameter int unsigned RX_INVERT    = 1,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned ARG_TIMEOUT  = 5000000,
  parameter int unsigned LINK_TIMEOUT = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_sevseg_num,
  output logic [3:0] o_buzz_freq,
  output logic       o_buzz_en,
  output logic       o_update,
  output logic       o_err,
  output logic [7:0] o_err_cnt,
  output logic       o_link_lost
);

  localparam logic [7:0] OP_SET_NUM  = 8'h01;
  localparam logic [7:0] OP_SET_FREQ = 8'h02;
  localparam logic [7:0] OP_MUTE     = 8'h03;
  localparam logic [7:0] OP_UNMUTE   = 8'h04;

  localparam int unsigned AT_W = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(ARG_TIMEOUT - 1);

  if (ARG_TIMEOUT == 0 || CLK_HZ == 0) begin : g_bad_param
    $error("ghostbox_cmd_ctrl: ARG_TIMEOUT and CLK_HZ must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ARG = 2'd1,
    S_APPLY    = 2'd2
`ifdef CMD_CHECKSUM_EN
    , S_WAIT_CSUM = 2'd3
`endif
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state_q, state_d;
  logic [AT_W-1:0] arg_cnt_q;
  logic [7:0]      rx_b;
  logic            op_valid, arg_expired, freq_bad;
  logic            cap_op, cap_arg, cnt_run, err_evt, apply_ok;
  logic [7:0]      op_p0, arg_p0;
  logic            buzz_en_q, link_lost;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]      csum_p0;
`endif

  assign rx_b        = (RX_INVERT != 0) ? ~i_rx_byte : i_rx_byte;
  assign op_valid    = (rx_b >= OP_SET_NUM) && (rx_b <= OP_UNMUTE);
  assign arg_expired = (arg_cnt_q == AT_LAST);
  assign freq_bad    = (op_p0 == OP_SET_FREQ) && (arg_p0[7:4] != 4'h0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      arg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arg_cnt_q <= cnt_run ? arg_cnt_q + AT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_done && op_valid) begin
          if (rx_b == OP_SET_NUM || rx_b == OP_SET_FREQ) state_d = S_WAIT_ARG;
`ifdef CMD_CHECKSUM_EN
          else state_d = S_WAIT_CSUM;
`else
          else state_d = S_APPLY;
`endif
        end
      end
      S_WAIT_ARG: begin
`ifdef CMD_CHECKSUM_EN
        if (i_rx_done) state_d = S_WAIT_CSUM;
`else
        if (i_rx_done) state_d = S_APPLY;
`endif
        else if (arg_expired) state_d = S_IDLE;
      end
`ifdef CMD_CHECKSUM_EN
      S_WAIT_CSUM: begin
        if (i_rx_done) state_d = (rx_b == csum_p0) ? S_APPLY : S_IDLE;
        else if (arg_expired) state_d = S_IDLE;
      end
`endif
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A byte arriving at the timeout edge still counts: rx_done is checked before expiry.
  always_comb begin
    cap_op   = 1'b0;
    cap_arg  = 1'b0;
    cnt_run  = 1'b0;
    err_evt  = 1'b0;
    apply_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        cap_op  = i_rx_done & op_valid;
        err_evt = i_rx_done & ~op_valid;
      end
      S_WAIT_ARG: begin
        cap_arg = i_rx_done;
        cnt_run = ~i_rx_done & ~arg_expired;
        err_evt = ~i_rx_done & arg_expired;
      end
`ifdef CMD_CHECKSUM_EN
      S_WAIT_CSUM: begin
        cnt_run = ~i_rx_done & ~arg_expired;
        err_evt = i_rx_done ? (rx_b != csum_p0) : arg_expired;
      end
`endif
      S_APPLY: begin
        apply_ok = ~freq_bad;
        err_evt  = freq_bad | i_rx_done;
      end
      default: ;
    endcase
  end

  // Stage p0: captured frame fields, consumed in APPLY.
  always_ff @(posedge i_clk) begin
    if (cap_op)  op_p0  <= rx_b;
    if (cap_arg) arg_p0 <= rx_b;
`ifdef CMD_CHECKSUM_EN
    if (cap_op)       csum_p0 <= rx_b;
    else if (cap_arg) csum_p0 <= csum_p0 ^ rx_b;
`endif
  end

  // Stage p1: output registers updated from the APPLY cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sevseg_num <= 8'h00;
      o_buzz_freq  <= 4'h1;
      buzz_en_q    <= 1'b1;
      o_update     <= 1'b0;
      o_err        <= 1'b0;
      o_err_cnt    <= 8'h00;
    end else begin
      o_update <= apply_ok;
      o_err    <= err_evt;
      if (err_evt) o_err_cnt <= sat_inc8(o_err_cnt);
      if (apply_ok) begin
        case (op_p0)
          OP_SET_NUM:  o_sevseg_num <= arg_p0;
          OP_SET_FREQ: o_buzz_freq  <= arg_p0[3:0];
          OP_MUTE:     buzz_en_q    <= 1'b0;
          default:     buzz_en_q    <= 1'b1;
        endcase
      end
    end
  end

  if (LINK_TIMEOUT > 0) begin : g_wdog
    localparam int unsigned WD_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(LINK_TIMEOUT);
    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                   wd_cnt_q <= '0;
      else if (apply_ok)           wd_cnt_q <= '0;
      else if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end

    assign link_lost = (wd_cnt_q == WD_MAX);
  end else begin : g_no_wdog
    assign link_lost = 1'b0;
  end

  // Link loss mutes at the port only; the commanded enable survives for recovery.
  assign o_buzz_en   = buzz_en_q & ~link_lost;
  assign o_link_lost = link_lost;

endmodule

// File: tb/tb_ghostbox_cmd_ctrl.sv
// Bench for ghostbox_cmd_ctrl: two instances (RX_INVERT=0 and 1) fed the same decoded stream,
// checked every cycle against a frame-level model; honours CMD_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_ghostbox_cmd_ctrl;
  localparam int unsigned AT = 16;
  localparam int unsigned LT = 100;

  logic       clk = 1'b0;
  logic       rst, rx_done;
  logic [7:0] raw0, raw1, d_byte;
  logic [7:0] num0, num1, errc0, errc1;
  logic [3:0] freq0, freq1;
  logic       en0, en1, upd0, upd1, err0, err1, lost0, lost1;

  always #5 clk = ~clk;

  ghostbox_cmd_ctrl #(.RX_INVERT(0), .CLK_HZ(50000000), .ARG_TIMEOUT(AT), .LINK_TIMEOUT(LT)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx_done(rx_done), .i_rx_byte(raw0),
    .o_sevseg_num(num0), .o_buzz_freq(freq0), .o_buzz_en(en0), .o_update(upd0),
    .o_err(err0), .o_err_cnt(errc0), .o_link_lost(lost0));

  ghostbox_cmd_ctrl #(.RX_INVERT(1), .CLK_HZ(50000000), .ARG_TIMEOUT(AT), .LINK_TIMEOUT(LT)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx_done(rx_done), .i_rx_byte(raw1),
    .o_sevseg_num(num1), .o_buzz_freq(freq1), .o_buzz_en(en1), .o_update(upd1),
    .o_err(err1), .o_err_cnt(errc1), .o_link_lost(lost1));

  // Model: expected output values visible in the current cycle.
  logic [7:0] m_num, m_errc;
  logic [3:0] m_freq;
  bit         m_en, m_upd, m_err, m_applying;
  int         m_wd;
  longint     cyc = 0, deadline = 0;
  logic [7:0] frame[$];
  int         total = 0, bad = 0;
  bit         chk_on = 0;

  function automatic int frame_len(input logic [7:0] op);
    int n;
    n = (op == 8'h01 || op == 8'h02) ? 2 : 1;
`ifdef CMD_CHECKSUM_EN
    n++;
`endif
    return n;
  endfunction

  function automatic bit csum_ok();
`ifdef CMD_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
    return x == frame[frame.size() - 1];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_num = 8'h00; m_freq = 4'h1; m_en = 1; m_upd = 0; m_err = 0;
    m_errc = 8'h00; m_wd = 0; m_applying = 0;
    frame.delete();
  endtask

  // Effect of one rising edge, given the inputs that were held across it.
  task automatic model_edge();
    bit e, u;
    logic [7:0] op, arg;
    cyc++;
    if (rst) begin model_reset(); return; end
    e = 0; u = 0;
    if (m_applying) begin
      op  = frame[0];
      arg = (frame.size() > 1) ? frame[1] : 8'h00;
      if (rx_done) e = 1;
      case (op)
        8'h01: begin m_num = arg; u = 1; end
        8'h02: if (arg[7:4] != 4'h0) e = 1; else begin m_freq = arg[3:0]; u = 1; end
        8'h03: begin m_en = 0; u = 1; end
        default: begin m_en = 1; u = 1; end
      endcase
      m_applying = 0;
      frame.delete();
    end else if (rx_done) begin
      if (frame.size() == 0 && (d_byte == 8'h00 || d_byte > 8'h04)) e = 1;
      else begin
        frame.push_back(d_byte);
        if (frame.size() == frame_len(frame[0])) begin
          if (csum_ok()) m_applying = 1;
          else begin e = 1; frame.delete(); end
        end else deadline = cyc + AT;
      end
    end else if (frame.size() != 0 && cyc == deadline) begin
      e = 1;
      frame.delete();
    end
    m_wd  = u ? 0 : ((m_wd < LT) ? m_wd + 1 : m_wd);
    m_upd = u;
    m_err = e;
    if (e && m_errc != 8'hFF) m_errc++;
  endtask

  function automatic logic [23:0] exp_vec();
    bit lost;
    lost = (m_wd >= LT);
    return {m_num, m_freq, m_en & ~lost, m_upd, m_err, m_errc, lost};
  endfunction

  task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h (num,freq,en,upd,err,errc,lost packed)",
               name, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("dut0", {num0, freq0, en0, upd0, err0, errc0, lost0}, exp_vec());
      cmp("dut1", {num1, freq1, en1, upd1, err1, errc1, lost1}, exp_vec());
    end
  end

  task automatic chk(input string name, input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] want);
    total++;
    if (a0 !== want || a1 !== want) begin
      bad++;
      $display("FAIL %s got dut0=%0h dut1=%0h want=%0h", name, a0, a1, want);
    end
  endtask

  task automatic step(input bit rx, input logic [7:0] d);
    rx_done = rx; d_byte = d; raw0 = d; raw1 = ~d;
    @(posedge clk);
    model_edge();
    #1;
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic frame_send(input logic [7:0] op, input logic [7:0] arg, input bit has_arg);
    logic [7:0] x;
    send(op);
    x = op;
    if (has_arg) begin send(arg); x ^= arg; end
`ifdef CMD_CHECKSUM_EN
    send(x);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;
  endtask

  task automatic gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 5)       idle(0);
    else if (r < 75) idle($urandom_range(1, 3));
    else if (r < 93) idle($urandom_range(14, 18));
    else             idle($urandom_range(90, 130));
  endtask

  initial begin
    logic [7:0] op, arg, x;
    rx_done = 1'b0; d_byte = 8'h00; raw0 = 8'h00; raw1 = 8'hFF;
    do_reset();
    chk_on = 1;
    chk("rst_num", num0, num1, 8'h00);
    chk("rst_freq", {4'h0, freq0}, {4'h0, freq1}, 8'h01);
    chk("rst_en", {7'h0, en0}, {7'h0, en1}, 8'h01);

    // Set number; update lands two cycles after the last byte.
    frame_send(8'h01, 8'h2A, 1);
    chk("num_upd_early", {7'h0, upd0}, {7'h0, upd1}, 8'h00);
    idle(1);
    chk("num_upd", {7'h0, upd0}, {7'h0, upd1}, 8'h01);
    chk("num_val", num0, num1, 8'h2A);
    chk("num_errc", errc0, errc1, 8'h00);

    // Frequency: legal 7, then 0x10 rejected.
    frame_send(8'h02, 8'h07, 1);
    idle(1);
    chk("freq_val", {4'h0, freq0}, {4'h0, freq1}, 8'h07);
    frame_send(8'h02, 8'h10, 1);
    idle(1);
    chk("freq_bad_err", {7'h0, err0}, {7'h0, err1}, 8'h01);
    chk("freq_bad_hold", {4'h0, freq0}, {4'h0, freq1}, 8'h07);
    chk("freq_bad_errc", errc0, errc1, 8'h01);

    // Argument timeout, then a mute still works.
    send(8'h01);
    idle(AT - 1);
    chk("to_not_yet", {7'h0, err0}, {7'h0, err1}, 8'h00);
    idle(1);
    chk("to_err", {7'h0, err0}, {7'h0, err1}, 8'h01);
    chk("to_errc", errc0, errc1, 8'h02);
    frame_send(8'h03, 8'h00, 0);
    idle(1);
    chk("mute_en", {7'h0, en0}, {7'h0, en1}, 8'h00);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin send(8'h09); idle(1); end
    chk("sat_errc", errc0, errc1, 8'hFF);
    chk("sat_num", num0, num1, 8'h2A);

    // Watchdog expiry and recovery.
    do_reset();
    idle(LT - 1);
    chk("wd_not_yet", {7'h0, lost0}, {7'h0, lost1}, 8'h00);
    idle(1);
    chk("wd_lost", {7'h0, lost0}, {7'h0, lost1}, 8'h01);
    chk("wd_en_forced", {7'h0, en0}, {7'h0, en1}, 8'h00);
    frame_send(8'h04, 8'h00, 0);
    idle(1);
    chk("wd_clear", {7'h0, lost0}, {7'h0, lost1}, 8'h00);
    chk("wd_en", {7'h0, en0}, {7'h0, en1}, 8'h01);
    chk("wd_upd", {7'h0, upd0}, {7'h0, upd1}, 8'h01);

    // Reset in the middle of a frame.
    frame_send(8'h01, 8'h33, 1);
    idle(1);
    send(8'h02);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_num", num0, num1, 8'h00);
    chk("midrst_freq", {4'h0, freq0}, {4'h0, freq1}, 8'h01);
    idle(1);
    rst = 1'b0;
    frame_send(8'h01, 8'h05, 1);
    idle(1);
    chk("midrst_after", num0, num1, 8'h05);
    chk("midrst_errc", errc0, errc1, 8'h00);

    // Byte landing in the APPLY cycle is dropped as an error.
    frame_send(8'h01, 8'h77, 1);
    send(8'h03);
    chk("drop_err", {7'h0, err0}, {7'h0, err1}, 8'h01);
    chk("drop_upd", {7'h0, upd0}, {7'h0, upd1}, 8'h01);
    idle(1);
    chk("drop_en", {7'h0, en0}, {7'h0, en1}, 8'h01);

`ifdef CMD_CHECKSUM_EN
    send(8'h01); send(8'h09); send(8'h08); idle(1);
    send(8'h01); send(8'h05); send(8'h04); idle(1);
    chk("csum_ok", num0, num1, 8'h05);
    send(8'h01); send(8'h05); send(8'h00);
    chk("csum_bad_err", {7'h0, err0}, {7'h0, err1}, 8'h01);
    idle(1);
    chk("csum_bad_hold", num0, num1, 8'h05);
`endif

    // Randomised frames, gaps straddling the timeouts, occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
      send(op);
      x = op;
      if (op == 8'h01 || op == 8'h02) begin
        gap();
        arg = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        send(arg);
        x ^= arg;
      end
`ifdef CMD_CHECKSUM_EN
      if (op >= 8'h01 && op <= 8'h04) begin
        gap();
        send(($urandom_range(0, 6) == 0) ? 8'($urandom) : x);
      end
`endif
      gap();
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
